// File: rtl/instr_reg_ctrl.sv
// Arbitrates two requesters into a circular instruction queue held in instr_register, with in-order drain and zero-fill flush.
// Latency: a push accepted at edge k drives load_en in cycle k..k+1, commits at edge k+1, and is readable from edge k+1.
// Backpressure: readies are low while the queue (committed + in-flight) is full, while flush_req is high, and while a flush is in progress.
module instr_reg_ctrl #(
   parameter int                DEPTH    = 32,
   parameter int                PTR_W    = 5,
   parameter int                OP_W     = 32,
   parameter int                OPC_W    = 4,
   parameter logic [OPC_W-1:0]  ZERO_OPC = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    s0_valid,
   output logic                    s0_ready,
   input  logic [OPC_W-1:0]        s0_opcode,
   input  logic signed [OP_W-1:0]  s0_operand_a,
   input  logic signed [OP_W-1:0]  s0_operand_b,
   input  logic                    s1_valid,
   output logic                    s1_ready,
   input  logic [OPC_W-1:0]        s1_opcode,
   input  logic signed [OP_W-1:0]  s1_operand_a,
   input  logic signed [OP_W-1:0]  s1_operand_b,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   input  logic                    flush_req,
   output logic                    busy,
   output logic [PTR_W:0]          count,
   output logic                    load_en,
   output logic [PTR_W-1:0]        write_pointer,
   output logic [PTR_W-1:0]        read_pointer,
   output logic [OPC_W-1:0]        opcode,
   output logic signed [OP_W-1:0]  operand_a,
   output logic signed [OP_W-1:0]  operand_b
);

   typedef enum logic [1:0] {ACTIVE, FLUSH_WAIT, FLUSH} state_t;

   localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W+2)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);

   state_t           state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             last_grant;

   logic [PTR_W+1:0] occupancy;
   logic             full;
   logic             can_grant;
   logic             grant0;
   logic             grant1;
   logic             commit;
   logic             rd_fire;

   // An in-flight load already owns a slot, so it counts toward full.
   assign occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, load_en};
   assign full      = (occupancy == DEPTH_OCC);
   assign can_grant = (state == ACTIVE) && !full && !flush_req;

   // Round-robin: on contention the requester that did not win last time goes next.
   assign grant0 = can_grant && s0_valid && (!s1_valid || last_grant);
   assign grant1 = can_grant && s1_valid && (!s0_valid || !last_grant);

   assign s0_ready      = grant0;
   assign s1_ready      = grant1;
   assign rd_valid      = (state == ACTIVE) && (count != '0);
   assign rd_fire       = rd_valid && rd_ready;
   // Flush writes also pulse load_en but are not queue entries.
   assign commit        = load_en && (state != FLUSH);
   assign write_pointer = wr_ptr;
   assign read_pointer  = rd_ptr;

   // Controller FSM: arbitration, pointer/count bookkeeping and the flush sequencer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ACTIVE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         load_en    <= 1'b0;
         busy       <= 1'b0;
         opcode     <= '0;
         operand_a  <= '0;
         operand_b  <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ACTIVE: begin
               if (commit) begin
                  wr_ptr <= wr_ptr + PTR_ONE;
               end
               if (rd_fire) begin
                  rd_ptr <= rd_ptr + PTR_ONE;
               end
               if (commit && !rd_fire) begin
                  count <= count + CNT_ONE;
               end else if (!commit && rd_fire) begin
                  count <= count - CNT_ONE;
               end
               load_en <= grant0 || grant1;
               if (grant0) begin
                  opcode     <= s0_opcode;
                  operand_a  <= s0_operand_a;
                  operand_b  <= s0_operand_b;
                  last_grant <= 1'b0;
               end else if (grant1) begin
                  opcode     <= s1_opcode;
                  operand_a  <= s1_operand_a;
                  operand_b  <= s1_operand_b;
                  last_grant <= 1'b1;
               end
               // Grants are blocked this cycle, so the only possible in-flight
               // load commits on this same edge.
               if (flush_req) begin
                  state <= FLUSH_WAIT;
                  busy  <= 1'b1;
               end
            end
            FLUSH_WAIT: begin
               // Set up the zero-fill; wr_ptr doubles as the fill index.
               wr_ptr    <= '0;
               load_en   <= 1'b1;
               opcode    <= ZERO_OPC;
               operand_a <= '0;
               operand_b <= '0;
               state     <= FLUSH;
            end
            FLUSH: begin
               wr_ptr <= wr_ptr + PTR_ONE;
               if (wr_ptr == LAST_IDX) begin
                  load_en <= 1'b0;
                  busy    <= 1'b0;
                  rd_ptr  <= '0;
                  count   <= '0;
                  state   <= ACTIVE;
               end
            end
            default: begin
               state <= ACTIVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl: handshakes, arbitration, wrap, concurrent read/write and flush.
// Outputs are sampled 1-2 time units after the rising edge.
// Inputs are driven with blocking assignments just after the rising edge.
module tb_instr_reg_ctrl;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               s0_valid, s1_valid;
   logic               s0_ready, s1_ready;
   logic [3:0]         s0_opcode, s1_opcode;
   logic signed [31:0] s0_operand_a, s0_operand_b, s1_operand_a, s1_operand_b;
   logic               rd_valid, rd_ready, flush_req, busy, load_en;
   logic [5:0]         count;
   logic [4:0]         write_pointer, read_pointer;
   logic [3:0]         opcode;
   logic signed [31:0] operand_a, operand_b;

   int checks   = 0;
   int failures = 0;

   instr_reg_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_opcode(s0_opcode),
      .s0_operand_a(s0_operand_a), .s0_operand_b(s0_operand_b),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_opcode(s1_opcode),
      .s1_operand_a(s1_operand_a), .s1_operand_b(s1_operand_b),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .flush_req(flush_req),
      .busy(busy), .count(count), .load_en(load_en),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s0_valid = 0; s1_valid = 0; rd_ready = 0; flush_req = 0;
      s0_opcode = 0; s0_operand_a = 0; s0_operand_b = 0;
      s1_opcode = 0; s1_operand_a = 0; s1_operand_b = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      #3;
      tick();
      reset_n = 1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      #3;
      checks++;
      if ({count, load_en, busy, rd_valid} !== 9'd0) begin
         failures++;
         $display("FAIL reset_ctrl count=%0d load_en=%0b busy=%0b rd_valid=%0b want 0", count, load_en, busy, rd_valid);
      end
      checks++;
      if ({write_pointer, read_pointer, opcode} !== 14'd0 || operand_a !== 0 || operand_b !== 0) begin
         failures++;
         $display("FAIL reset_data wp=%0d rp=%0d opc=%0d a=%0d b=%0d want 0", write_pointer, read_pointer, opcode, operand_a, operand_b);
      end
      tick();
      reset_n = 1;
      tick();
   endtask

   task automatic test_single_push();
      do_reset();
      // rd_ready while empty must be ignored
      rd_ready = 1;
      tick();
      rd_ready = 0;
      checks++;
      if (count !== 6'd0 || read_pointer !== 5'd0) begin
         failures++;
         $display("FAIL empty_read count=%0d rp=%0d want 0 0", count, read_pointer);
      end
      s0_valid = 1; s0_opcode = 4'd1; s0_operand_a = 5; s0_operand_b = 3;
      #1;
      checks++;
      if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_ready s0=%0b s1=%0b want 1 0", s0_ready, s1_ready);
      end
      tick();
      s0_valid = 0;
      #1;
      checks++;
      if (load_en !== 1'b1 || write_pointer !== 5'd0 || s0_ready !== 1'b0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_load load_en=%0b wp=%0d s0_ready=%0b rd_valid=%0b want 1 0 0 0", load_en, write_pointer, s0_ready, rd_valid);
      end
      checks++;
      if (opcode !== 4'd1 || operand_a !== 5 || operand_b !== 3) begin
         failures++;
         $display("FAIL single_payload opc=%0d a=%0d b=%0d want 1 5 3", opcode, operand_a, operand_b);
      end
      tick();
      checks++;
      if (count !== 6'd1 || rd_valid !== 1'b1 || read_pointer !== 5'd0 || load_en !== 1'b0 || write_pointer !== 5'd1) begin
         failures++;
         $display("FAIL single_commit count=%0d rd_valid=%0b rp=%0d load_en=%0b wp=%0d want 1 1 0 0 1", count, rd_valid, read_pointer, load_en, write_pointer);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      s0_valid = 1; s0_opcode = 4'd2; s0_operand_a = -7;
      s1_valid = 1; s1_opcode = 4'd3; s1_operand_a = 100;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (s0_ready !== (i % 2 == 0) || s1_ready !== (i % 2 == 1)) begin
            failures++;
            $display("FAIL alt_grant[%0d] s0=%0b s1=%0b want %0b %0b", i, s0_ready, s1_ready, i % 2 == 0, i % 2 == 1);
         end
         tick();
         checks++;
         if (load_en !== 1'b1 || write_pointer !== 5'(i) || opcode !== ((i % 2 == 0) ? 4'd2 : 4'd3)
             || operand_a !== ((i % 2 == 0) ? -7 : 100)) begin
            failures++;
            $display("FAIL alt_load[%0d] load_en=%0b wp=%0d opc=%0d a=%0d", i, load_en, write_pointer, opcode, operand_a);
         end
      end
      s0_valid = 0; s1_valid = 0;
      tick();
      checks++;
      if (count !== 6'd6 || load_en !== 1'b0) begin
         failures++;
         $display("FAIL alt_count count=%0d load_en=%0b want 6 0", count, load_en);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      s0_valid = 1;
      for (int i = 0; i < 32; i++) begin
         s0_opcode = 4'(i);
         tick();
      end
      s1_valid = 1;
      #1;
      checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_inflight_ready s0=%0b s1=%0b want 0 0", s0_ready, s1_ready);
      end
      tick();
      checks++;
      if (count !== 6'd32 || s0_ready !== 1'b0 || s1_ready !== 1'b0 || rd_valid !== 1'b1 || load_en !== 1'b0) begin
         failures++;
         $display("FAIL full_state count=%0d s0=%0b s1=%0b rd_valid=%0b load_en=%0b want 32 0 0 1 0", count, s0_ready, s1_ready, rd_valid, load_en);
      end
      rd_ready = 1;
      tick();
      rd_ready = 0;
      #1;
      // s0 won last, so s1 gets the freed slot
      checks++;
      if (count !== 6'd31 || read_pointer !== 5'd1 || s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_drain count=%0d rp=%0d s0=%0b s1=%0b want 31 1 0 1", count, read_pointer, s0_ready, s1_ready);
      end
      tick();
      s0_valid = 0; s1_valid = 0;
      checks++;
      if (load_en !== 1'b1 || write_pointer !== 5'd0) begin
         failures++;
         $display("FAIL wrap_push load_en=%0b wp=%0d want 1 0", load_en, write_pointer);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      s0_valid = 1;
      repeat (4) tick();
      s0_valid = 0;
      tick();
      checks++;
      if (count !== 6'd4 || write_pointer !== 5'd4) begin
         failures++;
         $display("FAIL b2b_prefill count=%0d wp=%0d want 4 4", count, write_pointer);
      end
      s0_valid = 1; rd_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         // one slot is always held by the in-flight load
         checks++;
         if (count !== 6'd3 || load_en !== 1'b1 || read_pointer !== 5'(i + 1)) begin
            failures++;
            $display("FAIL b2b_step[%0d] count=%0d load_en=%0b rp=%0d want 3 1 %0d", i, count, load_en, read_pointer, i + 1);
         end
      end
      s0_valid = 0; rd_ready = 0;
      tick();
      checks++;
      if (count !== 6'd4 || read_pointer !== 5'd3 || write_pointer !== 5'd7) begin
         failures++;
         $display("FAIL b2b_final count=%0d rp=%0d wp=%0d want 4 3 7", count, read_pointer, write_pointer);
      end
   endtask

   task automatic test_flush();
      int busy_cycles;
      int loads;
      busy_cycles = 0;
      loads = 0;
      do_reset();
      s0_valid = 1; s0_opcode = 4'd9; s0_operand_a = 11; s0_operand_b = -2;
      tick();
      flush_req = 1;
      #1;
      checks++;
      if (s0_ready !== 1'b0 || load_en !== 1'b1 || opcode !== 4'd9) begin
         failures++;
         $display("FAIL flush_block s0_ready=%0b load_en=%0b opc=%0d want 0 1 9", s0_ready, load_en, opcode);
      end
      tick();
      flush_req = 0;
      checks++;
      if (busy !== 1'b1 || count !== 6'd1 || load_en !== 1'b0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_wait busy=%0b count=%0d load_en=%0b rd_valid=%0b want 1 1 0 0", busy, count, load_en, rd_valid);
      end
      for (int i = 0; i < 40 && busy; i++) begin
         busy_cycles++;
         checks++;
         if (s0_ready !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready[%0d] s0=%0b rd_valid=%0b want 0 0", i, s0_ready, rd_valid);
         end
         if (load_en) begin
            checks++;
            if (write_pointer !== 5'(loads) || opcode !== 4'd0 || operand_a !== 0 || operand_b !== 0) begin
               failures++;
               $display("FAIL flush_load[%0d] wp=%0d opc=%0d a=%0d b=%0d want %0d 0 0 0", loads, write_pointer, opcode, operand_a, operand_b, loads);
            end
            loads++;
         end
         tick();
      end
      checks++;
      if (busy_cycles != 33 || loads != 32) begin
         failures++;
         $display("FAIL flush_len busy_cycles=%0d loads=%0d want 33 32", busy_cycles, loads);
      end
      checks++;
      if (busy !== 1'b0 || count !== 6'd0 || write_pointer !== 5'd0 || read_pointer !== 5'd0 || rd_valid !== 1'b0 || load_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_end busy=%0b count=%0d wp=%0d rp=%0d rd_valid=%0b load_en=%0b want all 0", busy, count, write_pointer, read_pointer, rd_valid, load_en);
      end
      checks++;
      if (s0_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_resume s0_ready=%0b want 1", s0_ready);
      end
      s0_valid = 0;
      tick();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      s0_valid = 1; s0_opcode = 4'd6; s0_operand_a = 1;
      tick();
      s0_valid = 0;
      tick();
      flush_req = 1;
      tick();
      flush_req = 0;
      for (int i = 0; i < 40 && write_pointer != 5'd10; i++) tick();
      checks++;
      if (write_pointer !== 5'd10 || busy !== 1'b1 || load_en !== 1'b1) begin
         failures++;
         $display("FAIL midflush_reach wp=%0d busy=%0b load_en=%0b want 10 1 1", write_pointer, busy, load_en);
      end
      #2;
      reset_n = 0;
      #1;
      checks++;
      if ({busy, load_en, count, write_pointer, read_pointer, opcode, rd_valid} !== 23'd0 || operand_a !== 0) begin
         failures++;
         $display("FAIL midflush_async busy=%0b load_en=%0b count=%0d wp=%0d rp=%0d opc=%0d a=%0d want all 0",
                  busy, load_en, count, write_pointer, read_pointer, opcode, operand_a);
      end
      tick();
      reset_n = 1;
      tick();
      s0_valid = 1;
      #1;
      checks++;
      if (s0_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midflush_active s0_ready=%0b busy=%0b want 1 0", s0_ready, busy);
      end
      s0_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_alternate();
      test_full_wrap();
      test_back_to_back();
      test_flush();
      test_reset_mid_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
